// File: rtl/grid_scan_pkg.sv
// grid_scan_pkg: shared state encoding and width helper for the grid scan sequencer
package grid_scan_pkg;
  typedef enum logic {IDLE, ISSUE} scan_state_t;
  function automatic int clog2_min1(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/grid_step.sv
// grid_step: raster-order successor of (x,y) with row-wrap flag and last-cell detect
module grid_step
  import grid_scan_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4
) (
  input  logic [clog2_min1(WIDTH)-1:0]  x,
  input  logic [clog2_min1(HEIGHT)-1:0] y,
  output logic [clog2_min1(WIDTH)-1:0]  nx,
  output logic [clog2_min1(HEIGHT)-1:0] ny,
  output logic                          wrap,
  output logic                          is_last
);
  localparam int XW = clog2_min1(WIDTH);
  localparam int YW = clog2_min1(HEIGHT);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  logic [YW-1:0] ys;
  // wrap selects the row increment; is_last flags whether the successor cell is the frame's final cell
  always_comb begin
    wrap    = (x == XMAX);
    nx      = wrap ? '0 : x + 1'b1;
    ny      = y + 1'b1;
    ys      = wrap ? ny : y;
    is_last = (nx == XMAX) && (ys == YMAX);
  end
endmodule

// File: rtl/grid_scan_ctrl.sv
// grid_scan_ctrl: raster-order cell coordinate sequencer with valid/ready output
module grid_scan_ctrl
  import grid_scan_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4,
  parameter int CONTINUOUS = 0
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic                                abort,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [clog2_min1(WIDTH)-1:0]        out_x,
  output logic [clog2_min1(HEIGHT)-1:0]       out_y,
  output logic [clog2_min1(WIDTH*HEIGHT)-1:0] out_addr,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done
);
  localparam int XW = clog2_min1(WIDTH);
  localparam int YW = clog2_min1(HEIGHT);
  localparam int AW = clog2_min1(WIDTH * HEIGHT);
  localparam logic ONE_CELL = (WIDTH * HEIGHT == 1);
  localparam logic WRAP_FRAME = (CONTINUOUS != 0);
  scan_state_t state, state_d;
  logic [XW-1:0] x_d, nx;
  logic [YW-1:0] y_d, ny;
  logic [AW-1:0] addr_d;
  logic last_d, done_d, wrap, nlast;
  grid_step #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_step (
    .x(out_x), .y(out_y), .nx(nx), .ny(ny), .wrap(wrap), .is_last(nlast)
  );
  assign out_valid = (state == ISSUE);
  assign busy      = out_valid;
  // next state and next beat: abort beats any same-cycle transfer, a frame restart zeroes the coordinates
  always_comb begin
    state_d = state;
    x_d     = out_x;
    y_d     = out_y;
    addr_d  = out_addr;
    last_d  = out_last;
    done_d  = 1'b0;
    if (state == IDLE) begin
      if (start && !abort) begin
        state_d = ISSUE;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        last_d  = ONE_CELL;
      end
    end else if (abort) begin
      state_d = IDLE;
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
      last_d  = 1'b0;
    end else if (out_ready) begin
      if (out_last) begin
        state_d = WRAP_FRAME ? ISSUE : IDLE;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
        last_d  = WRAP_FRAME && ONE_CELL;
        done_d  = 1'b1;
      end else begin
        x_d    = nx;
        y_d    = wrap ? ny : out_y;
        addr_d = out_addr + 1'b1;
        last_d = nlast;
      end
    end
  end
  // state, beat and done registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      out_x    <= '0;
      out_y    <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      out_x    <= x_d;
      out_y    <= y_d;
      out_addr <= addr_d;
      out_last <= last_d;
      done     <= done_d;
    end
  end
endmodule

// File: tb/tb_grid_scan_ctrl.sv
// tb_grid_scan_ctrl: scoreboard bench for one-shot, continuous and single-cell sequencers
module tb_grid_scan_ctrl;
  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;
  logic a_start = 0, a_abort = 0, a_ready = 0, a_valid, a_last, a_busy, a_done;
  logic [1:0] a_x, a_y;
  logic [3:0] a_addr;
  logic b_start = 0, b_abort = 0, b_ready = 0, b_valid, b_last, b_busy, b_done;
  logic [1:0] b_x, b_y;
  logic [3:0] b_addr;
  logic c_start = 0, c_abort = 0, c_ready = 0, c_valid, c_last, c_busy, c_done;
  logic c_x, c_y, c_addr;
  grid_scan_ctrl #(.WIDTH(4), .HEIGHT(3), .CONTINUOUS(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(a_start), .abort(a_abort),
    .out_valid(a_valid), .out_ready(a_ready), .out_x(a_x), .out_y(a_y),
    .out_addr(a_addr), .out_last(a_last), .busy(a_busy), .done(a_done));
  grid_scan_ctrl #(.WIDTH(4), .HEIGHT(3), .CONTINUOUS(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .abort(b_abort),
    .out_valid(b_valid), .out_ready(b_ready), .out_x(b_x), .out_y(b_y),
    .out_addr(b_addr), .out_last(b_last), .busy(b_busy), .done(b_done));
  grid_scan_ctrl #(.WIDTH(1), .HEIGHT(1), .CONTINUOUS(0)) dut_c (
    .clock(clock), .reset_n(reset_n), .start(c_start), .abort(c_abort),
    .out_valid(c_valid), .out_ready(c_ready), .out_x(c_x), .out_y(c_y),
    .out_addr(c_addr), .out_last(c_last), .busy(c_busy), .done(c_done));
  int n_chk = 0, n_fail = 0;
  int qa[$], qb[$], qc[$];
  int a_dn = 0, b_dn = 0, c_dn = 0;
  int a_beat, b_beat, c_beat, a_pbeat;
  logic a_dexp = 0, b_dexp = 0, c_dexp = 0, a_pv = 0, a_pr = 0, a_pab = 0, rnd = 0;
  assign a_beat = {23'd0, a_addr, a_y, a_x, a_last};
  assign b_beat = {23'd0, b_addr, b_y, b_x, b_last};
  assign c_beat = {26'd0, c_addr, 1'b0, c_y, 1'b0, c_x, c_last};
  function automatic int pk(int x, int y, int a, int l);
    return (a << 5) | (y << 3) | (x << 1) | l;
  endfunction
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  task automatic push_a(int n);
    for (int i = 0; i < n; i++) qa.push_back(pk(i % 4, (i / 4) % 3, i % 12, int'(i % 12 == 11)));
  endtask
  task automatic push_b(int n);
    for (int i = 0; i < n; i++) qb.push_back(pk(i % 4, (i / 4) % 3, i % 12, int'(i % 12 == 11)));
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  always @(negedge clock) begin
    if (!reset_n) begin
      a_dexp = 0;
      a_pv = 0;
    end else begin
      if (a_done || a_dexp) chk("A_done_pulse", int'(a_done), int'(a_dexp));
      if (a_done) begin
        a_dn++;
        chk("A_idle_at_done", int'({a_valid, a_busy}), 0);
      end
      if (a_pv && !a_pr && !a_pab) begin
        chk("A_stall_valid", int'(a_valid), 1);
        chk("A_stall_hold", a_beat, a_pbeat);
      end
      if (a_valid && a_ready) begin
        if (qa.size() == 0) chk("A_extra_beat", a_beat, -1);
        else chk("A_beat", a_beat, qa.pop_front());
      end
      a_dexp = a_valid && a_ready && a_last && !a_abort;
      a_pv = a_valid;
      a_pr = a_ready;
      a_pab = a_abort;
      a_pbeat = a_beat;
    end
  end
  always @(negedge clock) begin
    if (!reset_n) b_dexp = 0;
    else begin
      if (b_done || b_dexp) chk("B_done_pulse", int'(b_done), int'(b_dexp));
      if (b_done) b_dn++;
      if (b_valid && b_ready) begin
        if (qb.size() == 0) chk("B_extra_beat", b_beat, -1);
        else chk("B_beat", b_beat, qb.pop_front());
      end
      b_dexp = b_valid && b_ready && b_last && !b_abort;
    end
  end
  always @(negedge clock) begin
    if (!reset_n) c_dexp = 0;
    else begin
      if (c_done || c_dexp) chk("C_done_pulse", int'(c_done), int'(c_dexp));
      if (c_done) c_dn++;
      if (c_valid && c_ready) begin
        if (qc.size() == 0) chk("C_extra_beat", c_beat, -1);
        else chk("C_beat", c_beat, qc.pop_front());
      end
      c_dexp = c_valid && c_ready && c_last && !c_abort;
    end
  end
  initial forever begin
    @(posedge clock);
    #1;
    if (rnd) a_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    int cyc;
    #12;
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_beat", a_beat, 0);
    chk("rst_busy_done", int'({a_busy, a_done}), 0);
    chk("rst_c_last", int'({c_valid, c_last}), 0);
    tick();
    reset_n = 1;
    tick();
    chk("idle_no_start", int'(a_valid), 0);
    push_a(12);
    a_ready = 1;
    a_start = 1;
    tick();
    a_start = 0;
    chk("A_first_valid", int'({a_valid, a_busy}), 3);
    cyc = 0;
    while (a_dn < 1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("A_t1_latency", cyc, 13);
    chk("A_t1_done_cnt", a_dn, 1);
    chk("A_t1_q_empty", qa.size(), 0);
    push_a(12);
    rnd = 1;
    a_start = 1;
    tick();
    a_start = 0;
    cyc = 0;
    while (a_dn < 2 && cyc < 300) begin
      tick();
      cyc++;
    end
    rnd = 0;
    a_ready = 1;
    chk("A_t2_done_cnt", a_dn, 2);
    chk("A_t2_q_empty", qa.size(), 0);
    tick();
    push_a(6);
    a_start = 1;
    tick();
    a_start = 0;
    cyc = 0;
    while (!(a_valid && a_addr == 4'd5) && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("A_abort_reach5", int'(a_addr), 5);
    a_abort = 1;
    tick();
    a_abort = 0;
    chk("A_abort_idle", int'({a_valid, a_busy}), 0);
    chk("A_abort_coords", a_beat, 0);
    tick();
    tick();
    chk("A_abort_no_done", a_dn, 2);
    chk("A_abort_q_empty", qa.size(), 0);
    push_a(12);
    a_start = 1;
    tick();
    a_start = 0;
    cyc = 0;
    while (a_dn < 3 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("A_restart_done_cnt", a_dn, 3);
    chk("A_restart_q_empty", qa.size(), 0);
    push_b(30);
    b_ready = 1;
    b_start = 1;
    tick();
    b_start = 0;
    cyc = 0;
    while (qb.size() > 0 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("B_cycles_30", cyc, 30);
    chk("B_next_beat", b_beat, pk(2, 1, 6, 0));
    b_ready = 0;
    b_abort = 1;
    tick();
    b_abort = 0;
    chk("B_abort_idle", int'({b_valid, b_busy}), 0);
    chk("B_done_cnt", b_dn, 2);
    qc.push_back(pk(0, 0, 0, 1));
    c_start = 1;
    tick();
    tick();
    chk("C_hold_beat", int'({c_valid, c_last}), 3);
    c_start = 0;
    c_ready = 1;
    tick();
    chk("C_idle_at_done", int'({c_valid, c_done}), 1);
    tick();
    chk("C_no_restart", int'(c_valid), 0);
    chk("C_done_cnt", c_dn, 1);
    chk("C_q_empty", qc.size(), 0);
    push_a(12);
    a_start = 1;
    tick();
    a_start = 0;
    tick();
    tick();
    tick();
    chk("A_mid_frame", int'(a_addr), 3);
    #3;
    reset_n = 0;
    #1;
    chk("A_async_rst_valid", int'({a_valid, a_busy, a_done}), 0);
    chk("A_async_rst_beat", a_beat, 0);
    qa.delete();
    tick();
    tick();
    reset_n = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("A_post_rst_idle", int'(a_valid), 0);
    chk("A_post_rst_done_cnt", a_dn, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
